inst_mem_ctrl: RTL and testbench

Parametrised, clocked instruction memory for the CPU fetch stage, replacing the fixed 1024-word combinational ROM. It adds configurable depth, data width and access latency, a req/ready/valid fetch handshake, and a write port for downloading programs at run time. It sits between the PC/IF stage and IF/ID, returning one instruction word per accepted request.

---
 rtl/inst_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_inst_mem_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_ctrl.sv
// rtl/inst_mem_ctrl.sv - clocked instruction memory with req/ready/valid fetch and a program load port
// Optional INSTMEM_ALIGN_CHECK_EN: misaligned or out-of-range fetches respond with err=1, data=0.
module inst_mem_ctrl #(
   parameter int ADDR_WIDTH  = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_CYCLES = 1,
   parameter     INIT_FILE   = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  req,
   input  logic [31:0]           addr,
   output logic                  ready,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  err,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] idx;
   logic                  accept;
   logic                  rd_now;
   logic                  rd_err;
   logic                  err_r;

   assign ready  = ce && (state != WAIT);
   assign valid  = (state == RESP);
   assign accept = req && ready;
   assign err    = err_r;

`ifdef INSTMEM_ALIGN_CHECK_EN
   logic [31:0] lat_addr;

   always_ff @(posedge clk) begin
      if (accept)
         lat_addr <= addr;
   end

   assign idx    = lat_addr[ADDR_WIDTH+1:2];
   assign rd_err = (lat_addr[1:0] != 2'b00) || ((lat_addr >> (ADDR_WIDTH + 2)) != 32'd0);
`else
   // Byte offset and upper bits are dropped, so fetches wrap modulo the array size.
   logic [ADDR_WIDTH-1:0] lat_idx;
   logic                  unused_addr;

   always_ff @(posedge clk) begin
      if (accept)
         lat_idx <= addr[ADDR_WIDTH+1:2];
   end

   assign idx         = lat_idx;
   assign rd_err      = 1'b0;
   assign unused_addr = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rd_now    = 1'b0;
      if (!ce) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state_nxt = WAIT;
                  cnt_nxt   = 4'(WAIT_CYCLES);
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt_nxt = cnt - 4'd1;
               end else begin
                  rd_now    = 1'b1;
                  state_nxt = RESP;
               end
            end
            RESP: begin
               if (accept) begin
                  state_nxt = WAIT;
                  cnt_nxt   = 4'(WAIT_CYCLES);
               end else begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
         data  <= '0;
         err_r <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (!ce) begin
            data  <= '0;
            err_r <= 1'b0;
         end else if (rd_now) begin
            err_r <= rd_err;
            if (rd_err)
               data <= '0;
            else
               data <= mem[idx];
         end
      end
   end

   // Separate write process: a same-edge read sees the old word.
   always_ff @(posedge clk) begin
      if (we && !rst)
         mem[waddr] <= wdata;
   end
endmodule

// File: tb/tb_inst_mem_ctrl.sv
// tb/tb_inst_mem_ctrl.sv - self-checking bench for inst_mem_ctrl, behavioural model plus directed vectors
// Works with or without INSTMEM_ALIGN_CHECK_EN defined.
module tb_inst_mem_ctrl;
   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int WC    = 1;
   localparam int DEPTH = 1 << AW;

   localparam logic [31:0] W0 = 32'h34011100;
   localparam logic [31:0] W1 = 32'h30020020;
   localparam logic [31:0] WB = 32'hDEADBEEF;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          ce    = 1'b1;
   logic          req   = 1'b0;
   logic [31:0]   addr  = 32'd0;
   logic          we    = 1'b0;
   logic [AW-1:0] waddr = '0;
   logic [DW-1:0] wdata = '0;
   logic          ready;
   logic          valid;
   logic          err;
   logic [DW-1:0] data;

   inst_mem_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .WAIT_CYCLES(WC)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .ce   (ce),
      .req  (req),
      .addr (addr),
      .ready(ready),
      .valid(valid),
      .data (data),
      .err  (err),
      .we   (we),
      .waddr(waddr),
      .wdata(wdata)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic bit is_bad(input logic [31:0] a);
      bit bad;
      bad = (a % 4 != 0) || (a >= 4 * DEPTH);
`ifdef INSTMEM_ALIGN_CHECK_EN
      return bad;
`else
      return 1'b0 & bad;
`endif
   endfunction

   // Model: a fetch is a pending read due WC+1 edges after acceptance; its response shows after that edge.
   logic [DW-1:0] mmem [DEPTH];
   int            edge_n  = 0;
   bit            m_pend  = 1'b0;
   int            m_due   = 0;
   logic [31:0]   m_addr  = 32'd0;
   bit            m_valid = 1'b0;
   logic [DW-1:0] m_data  = '0;
   bit            m_err   = 1'b0;
   bit            chk_en  = 1'b0;

   always @(posedge clk) begin
      bit acc;
      acc = ce && req && !m_pend && !rst;
      m_valid = 1'b0;
      if (rst || !ce) begin
         m_pend = 1'b0;
         m_data = '0;
         m_err  = 1'b0;
         if (rst)
            chk_en = 1'b1;
      end else begin
         if (m_pend && edge_n == m_due) begin
            m_pend  = 1'b0;
            m_valid = 1'b1;
            m_err   = is_bad(m_addr);
            m_data  = m_err ? '0 : mmem[(m_addr / 4) % DEPTH];
         end
         if (acc) begin
            m_pend = 1'b1;
            m_due  = edge_n + WC + 1;
            m_addr = addr;
         end
      end
      if (we && !rst)
         mmem[waddr] = wdata;
      edge_n++;
   end

   always @(posedge clk) begin
      #2;
      if (chk_en) begin
         chk("cyc_valid", 32'(valid), 32'(m_valid));
         chk("cyc_ready", 32'(ready), 32'(ce && !m_pend));
         chk("cyc_data", data, m_data);
         if (m_valid)
            chk("cyc_err", 32'(err), 32'(m_err));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_valid(input int maxc, output int c);
      c = 0;
      while (valid !== 1'b1 && c < maxc) begin
         tick();
         c++;
      end
      chk("valid_timeout", 32'(valid), 32'd1);
   endtask

   task automatic fetch(input logic [31:0] a, output int c);
      req  = 1'b1;
      addr = a;
      tick();
      req = 1'b0;
      wait_valid(10, c);
      c++;
   endtask

   initial begin
      int c;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_data", data, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);

      we = 1'b1;
      waddr = 10'd0; wdata = W0; tick();
      waddr = 10'd1; wdata = W1; tick();
      waddr = 10'd5; wdata = 32'd0; tick();
      we = 1'b0;

      req = 1'b1; addr = 32'd0;
      tick();
      req = 1'b0;
      chk("t1_ready_after_e0", 32'(ready), 32'd0);
      tick();
      chk("t1_ready_after_e1", 32'(ready), 32'd0);
      chk("t1_valid_after_e1", 32'(valid), 32'd0);
      tick();
      chk("t1_valid_after_e2", 32'(valid), 32'd1);
      chk("t1_data", data, W0);
      chk("t1_err", 32'(err), 32'd0);
      chk("t1_ready_resp", 32'(ready), 32'd1);
      tick();
      chk("t1_valid_pulse", 32'(valid), 32'd0);
      chk("t1_data_held", data, W0);

      req = 1'b1; addr = 32'd0;
      tick();
      addr = 32'd4;
      wait_valid(10, c);
      chk("t2_latency", 32'(c), 32'd2);
      chk("t2_data0", data, W0);
      tick();
      req = 1'b0;
      wait_valid(10, c);
      chk("t2_gap", 32'(c + 1), 32'd3);
      chk("t2_data1", data, W1);
      tick();

      fetch(32'h2, c);
`ifdef INSTMEM_ALIGN_CHECK_EN
      chk("t3_misalign_err", 32'(err), 32'd1);
      chk("t3_misalign_data", data, 32'd0);
`else
      chk("t3_misalign_err", 32'(err), 32'd0);
      chk("t3_misalign_data", data, W0);
`endif
      tick();
      fetch(32'h1000, c);
`ifdef INSTMEM_ALIGN_CHECK_EN
      chk("t3_range_err", 32'(err), 32'd1);
      chk("t3_range_data", data, 32'd0);
`else
      chk("t3_wrap_err", 32'(err), 32'd0);
      chk("t3_wrap_data", data, W0);
`endif
      chk("t3_latency", 32'(c), 32'd3);
      tick();

      req = 1'b1; addr = 32'd20;
      tick();
      req = 1'b0;
      tick();
      we = 1'b1; waddr = 10'd5; wdata = WB;
      tick();
      we = 1'b0;
      chk("t4_rbw_valid", 32'(valid), 32'd1);
      chk("t4_rbw_data", data, 32'd0);
      tick();
      fetch(32'd20, c);
      chk("t4_new_data", data, WB);
      tick();

      req = 1'b1; addr = 32'd0;
      tick();
      req = 1'b0;
      ce  = 1'b0;
      #1;
      chk("t5_ready_comb", 32'(ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_valid", 32'(valid), 32'd0);
         chk("t5_data", data, 32'd0);
         chk("t5_ready", 32'(ready), 32'd0);
      end
      ce = 1'b1;
      #1;
      chk("t5_ready_back", 32'(ready), 32'd1);
      fetch(32'd0, c);
      chk("t5_latency", 32'(c), 32'd3);
      chk("t5_data_after", data, W0);
      tick();

      req = 1'b1; addr = 32'd0;
      tick();
      req = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6w_valid", 32'(valid), 32'd0);
      chk("t6w_data", data, 32'd0);
      chk("t6w_err", 32'(err), 32'd0);
      chk("t6w_ready", 32'(ready), 32'd1);
      tick();
      tick();
      chk("t6w_no_resp", 32'(valid), 32'd0);

      fetch(32'd4, c);
      chk("t6r_pre_data", data, W1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6r_valid", 32'(valid), 32'd0);
      chk("t6r_data", data, 32'd0);
      chk("t6r_ready", 32'(ready), 32'd1);
      fetch(32'd0, c);
      chk("t6_keep_w0", data, W0);
      tick();
      fetch(32'd20, c);
      chk("t6_keep_w5", data, WB);
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
